cpc_iowr_capture: RTL and testbench
===================================

# cpc_iowr_capture

Synchronous front end that watches the Amstrad CPC expansion bus for Z80 I/O write cycles addressed to the gate array RAM-configuration port (A15=0, data D7:D6=11). It samples the asynchronous bus with a local sample clock, filters glitches, and emits exactly one clean strobe per qualifying bus cycle. Its outputs drive the RAM-banking register and SRAM high-address decode directly downstream.

## Interface
- FILT_LEN, 2: consecutive qualifying samples needed to accept a cycle; legal range 1..15.
- CNT_W, 8: width of WRCOUNT.

- CLK  input  1  sample clock, at least 4x the Z80 clock.
- RESET  input  1  synchronous, active-high.
- IOREQ_B, WR_B, M1_B  input  1 each  raw Z80 bus strobes, active-low.
- A15, A14  input  1 each  raw address bits.
- D  input  8  raw data bus, D[7:0].
- CFG_STB  output  1  one-CLK pulse when a configuration write is accepted.
- CFG_DATA  output  6  D[5:0] captured at acceptance; holds until the next accepted write.
- CFG_VALID  output  1  high from the first accepted write after reset.
- WRCOUNT  output  CNT_W  number of accepted configuration writes, modulo 2^CNT_W.
- BUSY  output  1  high whenever the FSM is not in IDLE.

## Operation
- Every raw input goes through a 2-flop synchronizer. On reset, strobe flops load 1 (inactive); address and data flops load 0.
- Qualify term: q = !IOREQ_B_s & !WR_B_s & M1_B_s & !A15_s. The `IOWR_STRICT_DECODE_EN` configuration below adds a term to q. M1_B low (interrupt acknowledge) never qualifies.
- ARM flag: cleared by reset and set on the first cycle with q=0. While ARM=0 the FSM stays in IDLE, so a bus cycle already in progress at reset is never captured.
- FSM states: IDLE, QUAL, HOLD.
  - IDLE: when ARM & q, set cnt=1. If FILT_LEN==1, take the accept action. Otherwise go to QUAL.
  - QUAL: if q=0, go to IDLE and clear cnt. Otherwise cnt++; when the new cnt equals FILT_LEN, take the accept action.
  - Accept action: go to HOLD. If D_s[7:6]==11, assert CFG_STB for one cycle, load CFG_DATA<=D_s[5:0], set CFG_VALID, and increment WRCOUNT. Otherwise make no output change, but still go to HOLD.
  - HOLD: stay until IOREQ_B_s=1 or WR_B_s=1, then go to IDLE. Only one acceptance per bus cycle, regardless of cycle length.
- WRCOUNT wraps from all-ones to 0 with no flag.
- A glitch shorter than FILT_LEN samples returns the FSM to IDLE with no output change.

## Timing
- Reset values: CFG_STB=0, CFG_DATA=0, CFG_VALID=0, WRCOUNT=0, BUSY=0, state=IDLE, cnt=0, ARM=0.
- Edge 0 is the first CLK edge at which the raw inputs satisfy q; the block is armed and the inputs are held.
  - Accept occurs at edge FILT_LEN+1; CFG_STB is high in the cycle that follows it.
  - CFG_DATA, CFG_VALID and WRCOUNT update on that same edge.
- BUSY rises at edge 2. It falls on the edge after the synchronized end of the cycle, i.e. 3 edges after the raw IOREQ_B or WR_B rises.
- The Z80 holds D stable throughout WR low, so data sampled at acceptance is valid whenever FILT_LEN samples span less than the WR low time.
- RESET takes precedence over every other event in the same cycle, including a simultaneous acceptance. A pending strobe is dropped and WRCOUNT is not incremented.
- Back-to-back bus cycles: a new cycle is recognised only after HOLD has seen the end of the previous one.

## Configuration
- `IOWR_STRICT_DECODE_EN` defined: q additionally requires A14_s=1. This gives full gate-array decode (A15=0, A14=1) and ignores other A15=0 devices.
- Not defined: A14 is ignored and only A15=0 is decoded, matching the existing board decode. The A14 synchronizer may be omitted.

## Test plan
- Nominal write (FILT_LEN=2): write 0xC5 with A15=0, held 12 CLKs -> one CFG_STB in the cycle after edge 3; CFG_DATA=0x05, CFG_VALID=1, WRCOUNT=1.
- Non-config data: write 0x85 -> BUSY pulses, no CFG_STB, CFG_DATA and WRCOUNT unchanged. Interrupt acknowledge with M1_B=0 and IOREQ_B=0 -> BUSY stays 0.
- Glitch: IOREQ_B and WR_B low for 1 CLK with data 0xC3 -> no strobe; WRCOUNT unchanged.
- Reset mid-cycle: assert RESET during a held write of 0xC7, release while the write is still held -> no strobe until that cycle ends. A following write of 0xC2 -> CFG_DATA=0x02, WRCOUNT=1.
- Wrap and back-to-back: 256 consecutive config writes, each separated by 4 idle CLKs -> 256 strobes; WRCOUNT returns to 0; exactly one strobe per write.
- Strict decode: with `IOWR_STRICT_DECODE_EN` defined, a write of 0xC1 with A14=0 gives no strobe and a write with A14=1 gives a strobe. Without the macro, both writes give a strobe.

Source files
------------

// File: rtl/cpc_iowr_capture.sv
// cpc_iowr_capture: synchronises the raw CPC expansion bus, filters glitches and
// emits one strobe per accepted gate-array RAM-configuration I/O write.
// Optional build macro: IOWR_STRICT_DECODE_EN. When it is defined, a write also
// needs A14=1, which gives full gate-array decode.
//
// state | meaning
// IDLE  | waiting for a qualifying bus cycle (only once armed)
// QUAL  | counting consecutive qualifying samples up to FILT_LEN
// HOLD  | cycle accepted; waiting for IOREQ_B or WR_B to return high
module cpc_iowr_capture #(
   parameter int FILT_LEN = 2,
   parameter int CNT_W    = 8
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             IOREQ_B,
   input  logic             WR_B,
   input  logic             M1_B,
   input  logic             A15,
   input  logic             A14,
   input  logic [7:0]       D,
   output logic             CFG_STB,
   output logic [5:0]       CFG_DATA,
   output logic             CFG_VALID,
   output logic [CNT_W-1:0] WRCOUNT,
   output logic             BUSY
);

   typedef enum logic [1:0] {IDLE, QUAL, HOLD} state_t;

   localparam logic [3:0]  FILT_CNT  = 4'(FILT_LEN);
   // {IOREQ_B, WR_B, M1_B, A15, D[7:0]}; strobes reset inactive, address/data to 0
   localparam logic [11:0] SYNC_RST  = 12'hE00;

   logic [11:0] bus_raw;
   logic [11:0] sync1_q, sync_q;
   logic        ioreq_b_s, wr_b_s, m1_b_s, a15_s;
   logic [7:0]  d_s;
   logic        q;

   assign bus_raw = {IOREQ_B, WR_B, M1_B, A15, D};
   assign {ioreq_b_s, wr_b_s, m1_b_s, a15_s, d_s} = sync_q;

   // two-flop synchroniser for every raw bus input
   always_ff @(posedge CLK) begin
      if (RESET) begin
         sync1_q <= SYNC_RST;
         sync_q  <= SYNC_RST;
      end else begin
         sync1_q <= bus_raw;
         sync_q  <= sync1_q;
      end
   end

`ifdef IOWR_STRICT_DECODE_EN
   logic a14_s1_q, a14_s_q;

   // A14 synchroniser, only needed for full gate-array decode
   always_ff @(posedge CLK) begin
      if (RESET) begin
         a14_s1_q <= 1'b0;
         a14_s_q  <= 1'b0;
      end else begin
         a14_s1_q <= A14;
         a14_s_q  <= a14_s1_q;
      end
   end

   assign q = !ioreq_b_s && !wr_b_s && m1_b_s && !a15_s && a14_s_q;
`else
   logic unused_a14;
   assign unused_a14 = A14;
   assign q = !ioreq_b_s && !wr_b_s && m1_b_s && !a15_s;
`endif

   state_t           state_q, state_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [1:0]       fill_q, fill_d;
   logic             arm_q, arm_d;
   logic             stb_q, stb_d;
   logic [5:0]       data_q, data_d;
   logic             valid_q, valid_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             busy_q, busy_d;
   logic             accept;

   // next-state and output computation for the capture FSM
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stb_d   = 1'b0;
      data_d  = data_q;
      valid_d = valid_q;
      count_d = count_q;
      accept  = 1'b0;

      // The synchroniser still holds its reset image for two cycles after reset.
      // Arming only counts a q=0 seen on genuine post-reset samples, so a write
      // already in progress at reset cannot arm the block and be captured.
      fill_d = (fill_q == 2'd2) ? fill_q : fill_q + 2'd1;
      arm_d  = arm_q || ((fill_q == 2'd2) && !q);

      case (state_q)
         IDLE: begin
            if (arm_q && q) begin
               cnt_d = 4'd1;
               if (FILT_LEN == 1) accept = 1'b1;
               else               state_d = QUAL;
            end
         end
         QUAL: begin
            if (!q) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end else begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_d == FILT_CNT) accept = 1'b1;
            end
         end
         HOLD: begin
            if (ioreq_b_s || wr_b_s) begin
               state_d = IDLE;
               cnt_d   = 4'd0;
            end
         end
         default: begin
            state_d = IDLE;
            cnt_d   = 4'd0;
         end
      endcase

      if (accept) begin
         state_d = HOLD;
         if (d_s[7:6] == 2'b11) begin
            stb_d   = 1'b1;
            data_d  = d_s[5:0];
            valid_d = 1'b1;
            count_d = count_q + CNT_W'(1);
         end
      end

      busy_d = (state_d != IDLE);
   end

   // FSM state and registered outputs; reset wins over a same-cycle accept
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         fill_q  <= 2'd0;
         arm_q   <= 1'b0;
         stb_q   <= 1'b0;
         data_q  <= 6'd0;
         valid_q <= 1'b0;
         count_q <= '0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fill_q  <= fill_d;
         arm_q   <= arm_d;
         stb_q   <= stb_d;
         data_q  <= data_d;
         valid_q <= valid_d;
         count_q <= count_d;
         busy_q  <= busy_d;
      end
   end

   assign CFG_STB   = stb_q;
   assign CFG_DATA  = data_q;
   assign CFG_VALID = valid_q;
   assign WRCOUNT   = count_q;
   assign BUSY      = busy_q;

endmodule

// File: tb/tb_cpc_iowr_capture.sv
// Directed bench for cpc_iowr_capture (FILT_LEN=2, CNT_W=8).
module tb_cpc_iowr_capture;

   logic       CLK = 1'b0;
   logic       RESET, IOREQ_B, WR_B, M1_B, A15, A14;
   logic [7:0] D;
   logic       CFG_STB, CFG_VALID, BUSY;
   logic [5:0] CFG_DATA;
   logic [7:0] WRCOUNT;

   int errors = 0;
   int checks = 0;
   int stb_cnt = 0;
   int stb_base;
   bit busy_seen = 1'b0;

   cpc_iowr_capture #(.FILT_LEN(2), .CNT_W(8)) dut (
      .CLK(CLK), .RESET(RESET), .IOREQ_B(IOREQ_B), .WR_B(WR_B), .M1_B(M1_B),
      .A15(A15), .A14(A14), .D(D), .CFG_STB(CFG_STB), .CFG_DATA(CFG_DATA),
      .CFG_VALID(CFG_VALID), .WRCOUNT(WRCOUNT), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   always @(negedge CLK) begin
      if (CFG_STB) stb_cnt++;
      if (BUSY) busy_seen = 1'b1;
   end

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic bus_idle();
      IOREQ_B = 1'b1; WR_B = 1'b1; M1_B = 1'b1; A15 = 1'b1; A14 = 1'b0; D = 8'h00;
   endtask

   // drive one bus cycle for 'len' clocks, release it, then idle for 'gap' clocks
   task automatic bus_cycle(input logic [7:0] dat, input logic a14v, input logic m1v,
                            input int len, input int gap);
      D = dat; A15 = 1'b0; A14 = a14v; M1_B = m1v; IOREQ_B = 1'b0; WR_B = 1'b0;
      step(len);
      bus_idle();
      step(gap);
   endtask

   initial begin
      RESET = 1'b1;
      bus_idle();
      step(3);
      check("rst_stb",   32'(CFG_STB),   32'd0);
      check("rst_data",  32'(CFG_DATA),  32'd0);
      check("rst_valid", 32'(CFG_VALID), 32'd0);
      check("rst_count", 32'(WRCOUNT),   32'd0);
      check("rst_busy",  32'(BUSY),      32'd0);
      RESET = 1'b0;
      step(6);

      // nominal write 0xC5, 12 clocks; times below are 1 unit after each edge
      stb_base = stb_cnt;
      D = 8'hC5; A15 = 1'b0; M1_B = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
      step(2);                                    // after edge 1
      check("nom_busy_e1", 32'(BUSY), 32'd0);
      step(1);                                    // after edge 2
      check("nom_busy_e2", 32'(BUSY), 32'd1);
      check("nom_stb_e2",  32'(CFG_STB), 32'd0);
      step(1);                                    // after edge 3
      check("nom_stb_e3",   32'(CFG_STB),   32'd1);
      check("nom_data_e3",  32'(CFG_DATA),  32'h05);
      check("nom_valid_e3", 32'(CFG_VALID), 32'd1);
      check("nom_count_e3", 32'(WRCOUNT),   32'd1);
      step(1);                                    // after edge 4
      check("nom_stb_e4",  32'(CFG_STB), 32'd0);
      check("nom_busy_e4", 32'(BUSY),    32'd1);
      step(8);                                    // after edge 12
      bus_idle();
      step(2);
      check("nom_busy_end2", 32'(BUSY), 32'd1);
      step(1);
      check("nom_busy_end3", 32'(BUSY), 32'd0);
      step(4);
      check("nom_one_stb", 32'(stb_cnt - stb_base), 32'd1);

      // non-config data: BUSY pulses, outputs unchanged
      stb_base = stb_cnt; busy_seen = 1'b0;
      bus_cycle(8'h85, 1'b0, 1'b1, 12, 6);
      check("nc_busy",  32'(busy_seen), 32'd1);
      check("nc_stb",   32'(stb_cnt - stb_base), 32'd0);
      check("nc_data",  32'(CFG_DATA), 32'h05);
      check("nc_count", 32'(WRCOUNT),  32'd1);

      // interrupt acknowledge (M1_B low) never qualifies
      stb_base = stb_cnt; busy_seen = 1'b0;
      bus_cycle(8'hC5, 1'b0, 1'b0, 12, 6);
      check("ack_busy", 32'(busy_seen), 32'd0);
      check("ack_stb",  32'(stb_cnt - stb_base), 32'd0);

      // one-clock glitch
      stb_base = stb_cnt;
      bus_cycle(8'hC3, 1'b0, 1'b1, 1, 6);
      check("gl_stb",   32'(stb_cnt - stb_base), 32'd0);
      check("gl_count", 32'(WRCOUNT), 32'd1);
      check("gl_data",  32'(CFG_DATA), 32'h05);

      // reset during a held write of 0xC7, released while still held
      D = 8'hC7; A15 = 1'b0; M1_B = 1'b1; IOREQ_B = 1'b0; WR_B = 1'b0;
      step(2);
      RESET = 1'b1;
      step(3);
      RESET = 1'b0;
      stb_base = stb_cnt;
      step(10);
      check("rm_stb",   32'(stb_cnt - stb_base), 32'd0);
      check("rm_valid", 32'(CFG_VALID), 32'd0);
      check("rm_count", 32'(WRCOUNT),   32'd0);
      check("rm_busy",  32'(BUSY),      32'd0);
      bus_idle();
      step(6);
      check("rm_after_stb", 32'(stb_cnt - stb_base), 32'd0);
      bus_cycle(8'hC2, 1'b0, 1'b1, 12, 6);
      check("rm_next_stb",   32'(stb_cnt - stb_base), 32'd1);
      check("rm_next_data",  32'(CFG_DATA),  32'h02);
      check("rm_next_count", 32'(WRCOUNT),   32'd1);
      check("rm_next_valid", 32'(CFG_VALID), 32'd1);

      // 256 back-to-back writes from a fresh reset: counter wraps to 0
      RESET = 1'b1;
      step(2);
      RESET = 1'b0;
      step(6);
      for (int i = 0; i < 256; i++) begin
         stb_base = stb_cnt;
         bus_cycle(8'hC0 | 8'(i % 64), 1'b0, 1'b1, 6, 4);
         check("wrap_one_stb", 32'(stb_cnt - stb_base), 32'd1);
         if (i == 254) check("wrap_count_255", 32'(WRCOUNT), 32'd255);
      end
      check("wrap_count", 32'(WRCOUNT),   32'd0);
      check("wrap_data",  32'(CFG_DATA),  32'h3F);
      check("wrap_valid", 32'(CFG_VALID), 32'd1);

      // A14 decode
      stb_base = stb_cnt;
      bus_cycle(8'hC1, 1'b0, 1'b1, 12, 6);
`ifdef IOWR_STRICT_DECODE_EN
      check("a14_lo_stb", 32'(stb_cnt - stb_base), 32'd0);
`else
      check("a14_lo_stb", 32'(stb_cnt - stb_base), 32'd1);
      check("a14_lo_data", 32'(CFG_DATA), 32'h01);
`endif
      stb_base = stb_cnt;
      bus_cycle(8'hC1, 1'b1, 1'b1, 12, 6);
      check("a14_hi_stb",  32'(stb_cnt - stb_base), 32'd1);
      check("a14_hi_data", 32'(CFG_DATA), 32'h01);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
